// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-bank types and the address decoder used by the bank and its benches.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b01
  } resp_e;

  typedef struct packed {
    logic        ok;
    logic [31:0] idx;
  } decode_t;

  // Aligned base means a sub-base address can never wrap into the window, so a 64-bit
  // subtraction gives the same verdict as one taken modulo 2^ADDR_WIDTH.
  function automatic decode_t addr_decode(input logic [63:0] addr, input logic [63:0] base,
                                          input int unsigned num_regs,
                                          input int unsigned bpw);
    logic [63:0] off;
    decode_t     dec;
    off     = addr - base;
    dec.ok  = (off < (64'(num_regs) * 64'(bpw))) && ((off & 64'(bpw - 1)) == 64'd0);
    dec.idx = 32'(off / 64'(bpw));
    return dec;
  endfunction

endpackage

// File: rtl/axil_wr_slot.sv
// One-deep holding register for an AXI write channel beat; freed by the bank on commit.
module axil_wr_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  input  logic             clear_i,
  output logic             held_o,
  output logic [Width-1:0] data_o
);

  logic             held_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else if (valid_i && !held_q) begin
      held_q <= 1'b1;
      data_q <= data_i;
    end else if (clear_i) begin
      held_q <= 1'b0;
    end
  end

  assign ready_o = !held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite register bank with read-only hardware-sourced registers.
// Define AXIL_REGBANK_WR_PULSE_EN to add the per-register wr_pulse_o strobe output.
module axi4_lite_regbank
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in_i,
`ifdef AXIL_REGBANK_WR_PULSE_EN
  output logic [NUM_REGS-1:0]            wr_pulse_o,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o
);

  localparam int unsigned Bpw  = DATA_WIDTH / 8;
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $fatal(1, "axi4_lite_regbank: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "axi4_lite_regbank: NUM_REGS must be a power of two >= 2");
  end
  if ((64'(BASE_ADDR) % 64'(NUM_REGS * Bpw)) != 64'd0) begin : g_bad_base
    $fatal(1, "axi4_lite_regbank: BASE_ADDR not aligned to bank size");
  end

  logic                              aw_held, w_held, commit;
  logic [ADDR_WIDTH-1:0]             aw_addr;
  logic [DATA_WIDTH+Bpw-1:0]         w_beat;
  logic [DATA_WIDTH-1:0]             w_data;
  logic [Bpw-1:0]                    w_strb;
  decode_t                           wr_dec, rd_dec;
  logic [IdxW-1:0]                   wr_idx, rd_idx;
  logic                              wr_ok;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, hw_vec;
  logic                              bvalid_q, rvalid_q;
  resp_e                             bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  logic                              unused_idx_bits;

  axil_wr_slot #(
    .Width(ADDR_WIDTH)
  ) u_aw_slot (
    .aclk   (aclk),
    .aresetn(aresetn),
    .valid_i(awvalid_i),
    .ready_o(awready_o),
    .data_i (awaddr_i),
    .clear_i(commit),
    .held_o (aw_held),
    .data_o (aw_addr)
  );

  axil_wr_slot #(
    .Width(DATA_WIDTH + Bpw)
  ) u_w_slot (
    .aclk   (aclk),
    .aresetn(aresetn),
    .valid_i(wvalid_i),
    .ready_o(wready_o),
    .data_i ({wstrb_i, wdata_i}),
    .clear_i(commit),
    .held_o (w_held),
    .data_o (w_beat)
  );

  assign w_data  = w_beat[DATA_WIDTH-1:0];
  assign w_strb  = w_beat[DATA_WIDTH +: Bpw];
  assign wr_dec  = addr_decode(64'(aw_addr), 64'(BASE_ADDR), NUM_REGS, Bpw);
  assign wr_idx  = wr_dec.idx[IdxW-1:0];
  assign wr_ok   = wr_dec.ok && !RO_MASK[wr_idx];
  // The B slot frees in the same cycle as its handshake, so a pending write can commit then.
  assign commit  = aw_held && w_held && (!bvalid_q || bready_i);

  assign rd_dec  = addr_decode(64'(araddr_i), 64'(BASE_ADDR), NUM_REGS, Bpw);
  assign rd_idx  = rd_dec.idx[IdxW-1:0];
  assign hw_vec  = hw_in_i;
  assign arready_o = !rvalid_q || rready_i;

  assign unused_idx_bits = ^{wr_dec.idx[31:IdxW], rd_dec.idx[31:IdxW]};

  // Read-only registers are never written, so their storage stays zero.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      regs_q <= '0;
    end else if (commit && wr_ok) begin
      for (int unsigned b = 0; b < Bpw; b++) begin
        if (w_strb[b]) regs_q[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? OKAY : SLVERR;
    end else if (bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  // regs_q is read before this edge's commit lands, giving pre-write data on a collision.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (arvalid_i && arready_o) begin
      rvalid_q <= 1'b1;
      if (!rd_dec.ok) begin
        rdata_q <= '0;
        rresp_q <= SLVERR;
      end else if (RO_MASK[rd_idx]) begin
        rdata_q <= hw_vec[rd_idx];
        rresp_q <= OKAY;
      end else begin
        rdata_q <= regs_q[rd_idx];
        rresp_q <= OKAY;
      end
    end else if (rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef AXIL_REGBANK_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && wr_ok && |w_strb) wr_pulse_q[wr_idx] <= 1'b1;
    end
  end

  assign wr_pulse_o = wr_pulse_q;
`endif

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;
  assign reg_q_o  = regs_q;

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed bench: a 32-bit bank with register 1 read-only, and a 64-bit bank at base 0x1000.
module tb_axi4_lite_regbank;
  import axil_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_q, hw_in;
  logic [31:0]  exp32 [16];

  logic [31:0]   s_awaddr, s_araddr;
  logic [63:0]   s_wdata, s_rdata;
  logic [7:0]    s_wstrb;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]    s_bresp, s_rresp;
  logic [1023:0] s_reg_q, s_hw_in;

  axi4_lite_regbank #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0), .RO_MASK(16'h0002)
  ) u_dut32 (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .hw_in_i(hw_in), .reg_q_o(reg_q)
  );

  axi4_lite_regbank #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_REGS(16), .BASE_ADDR(32'h1000), .RO_MASK(16'h0000)
  ) u_dut64 (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr_i(s_awaddr), .awvalid_i(s_awvalid), .awready_o(s_awready),
    .wdata_i(s_wdata), .wstrb_i(s_wstrb), .wvalid_i(s_wvalid), .wready_o(s_wready),
    .bresp_o(s_bresp), .bvalid_o(s_bvalid), .bready_i(s_bready),
    .araddr_i(s_araddr), .arvalid_i(s_arvalid), .arready_o(s_arready),
    .rdata_o(s_rdata), .rresp_o(s_rresp), .rvalid_o(s_rvalid), .rready_i(s_rready),
    .hw_in_i(s_hw_in), .reg_q_o(s_reg_q)
  );

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r, output bit to);
    int n;
    logic ag, wg;
    @(negedge aclk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(negedge aclk);
      if (ag) awvalid = 1'b0;
      if (wg) wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < 40) begin
      @(negedge aclk);
      n++;
    end
    to = !bvalid;
    r = bresp;
    awvalid = 1'b0; wvalid = 1'b0;
    if (bvalid) @(negedge aclk);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                      output bit to);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    to = !rvalid;
    d = rdata;
    r = rresp;
  endtask

  task automatic wr64(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      output logic [1:0] r, output bit to);
    int n;
    logic ag, wg;
    @(negedge aclk);
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; s_bready = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 20) begin
      ag = s_awvalid && s_awready;
      wg = s_wvalid && s_wready;
      @(negedge aclk);
      if (ag) s_awvalid = 1'b0;
      if (wg) s_wvalid = 1'b0;
      n++;
    end
    while (!s_bvalid && n < 40) begin
      @(negedge aclk);
      n++;
    end
    to = !s_bvalid;
    r = s_bresp;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (s_bvalid) @(negedge aclk);
  endtask

  task automatic rd64(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r,
                      output bit to);
    int n;
    @(negedge aclk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    s_arvalid = 1'b0;
    to = !s_rvalid;
    d = s_rdata;
    r = s_rresp;
  endtask

  task automatic test_reset();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
    hw_in = '0; hw_in[32 +: 32] = 32'hCAFE_0001; s_hw_in = '0;
    for (int i = 0; i < 16; i++) exp32[i] = '0;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      bad++;
      $display("FAIL reset32 ready/valid: got %b want 11100",
               {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({bresp, rresp, rdata} !== 36'd0 || reg_q !== '0) begin
      bad++;
      $display("FAIL reset32 data: got bresp=%0d rresp=%0d rdata=%h want 0", bresp, rresp, rdata);
    end
    total++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100 ||
        {s_bresp, s_rresp, s_rdata} !== 68'd0 || s_reg_q !== '0) begin
      bad++;
      $display("FAIL reset64: got rdy/vld=%b rdata=%h want 11100/0",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, s_rdata);
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_basic_write();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    @(negedge aclk);
    awaddr = 32'h08; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    total++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      bad++;
      $display("FAIL basic held: got aw/w/b=%b want 000", {awready, wready, bvalid});
    end
    @(negedge aclk);
    total++;
    if (bvalid !== 1'b1 || bresp !== OKAY || reg_q[64 +: 32] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL basic bresp: got bvalid=%b bresp=%0d reg2=%h want 1/0/deadbeef",
               bvalid, bresp, reg_q[64 +: 32]);
    end
    exp32[2] = 32'hDEAD_BEEF;
    rd32(32'h08, d, r, to);
    total++;
    if (to || d !== 32'hDEAD_BEEF || r !== OKAY) begin
      bad++;
      $display("FAIL basic read: got %h/%0d to=%0d want deadbeef/0", d, r, to);
    end
  endtask

  task automatic test_strobe_order();
    logic [1:0] r;
    bit         to;
    wr32(32'h0C, 32'hFFFF_FFFF, 4'hF, r, to);
    @(negedge aclk);
    wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1; awvalid = 0; bready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      wvalid = 0;
      total++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        bad++;
        $display("FAIL w_first cyc%0d: got w/aw/b=%b want 010", i, {wready, awready, bvalid});
      end
    end
    awaddr = 32'h0C; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    @(negedge aclk);
    total++;
    if (to || bvalid !== 1'b1 || bresp !== OKAY || reg_q[96 +: 32] !== 32'hFF22_FF44) begin
      bad++;
      $display("FAIL strobe: got bvalid=%b bresp=%0d reg3=%h want 1/0/ff22ff44",
               bvalid, bresp, reg_q[96 +: 32]);
    end
    exp32[3] = 32'hFF22_FF44;
  endtask

  task automatic test_read_only();
    logic [31:0] d;
    logic [1:0]  r;
    bit          to;
    wr32(32'h04, 32'h1234_5678, 4'hF, r, to);
    total++;
    if (to || r !== SLVERR || reg_q[32 +: 32] !== 32'h0) begin
      bad++;
      $display("FAIL ro write: got %0d reg1=%h to=%0d want 1/0", r, reg_q[32 +: 32], to);
    end
    rd32(32'h04, d, r, to);
    total++;
    if (to || d !== 32'hCAFE_0001 || r !== OKAY) begin
      bad++;
      $display("FAIL ro read: got %h/%0d want cafe0001/0", d, r);
    end
    wr32(32'h08, 32'h1234_5678, 4'h0, r, to);
    total++;
    if (to || r !== OKAY || reg_q[64 +: 32] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL zero strb: got %0d reg2=%h want 0/deadbeef", r, reg_q[64 +: 32]);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0]  addrs [3];
    logic [31:0]  d;
    logic [1:0]   r;
    bit           to;
    logic [511:0] e;
    addrs[0] = 32'h40; addrs[1] = 32'h06; addrs[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      rd32(addrs[i], d, r, to);
      total++;
      if (to || d !== 32'h0 || r !== SLVERR) begin
        bad++;
        $display("FAIL bad read %h: got %h/%0d want 0/1", addrs[i], d, r);
      end
    end
    wr32(32'h40, 32'hAAAA_5555, 4'hF, r, to);
    e = '0;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = exp32[i];
    total++;
    if (to || r !== SLVERR || reg_q !== e) begin
      bad++;
      $display("FAIL bad write: got resp=%0d reg_q=%h want 1/%h", r, reg_q, e);
    end
  endtask

  task automatic test_b_backpressure();
    @(negedge aclk);
    awaddr = 32'h10; wdata = 32'hAAAA_0001; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    total++;
    if ({bvalid, awready, wready} !== 3'b111 || bresp !== OKAY ||
        reg_q[128 +: 32] !== 32'hAAAA_0001) begin
      bad++;
      $display("FAIL bp first: got b/aw/w=%b bresp=%0d reg4=%h want 111/0/aaaa0001",
               {bvalid, awready, wready}, bresp, reg_q[128 +: 32]);
    end
    exp32[4] = 32'hAAAA_0001;
    awaddr = 32'h04; wdata = 32'hBBBB_0002; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    total++;
    if ({awready, wready} !== 2'b00) begin
      bad++;
      $display("FAIL bp second accept: got aw/w=%b want 00", {awready, wready});
    end
    repeat (4) @(negedge aclk);
    total++;
    if (bvalid !== 1'b1 || bresp !== OKAY || awready !== 1'b0) begin
      bad++;
      $display("FAIL bp stall: got bvalid=%b bresp=%0d awready=%b want 1/0/0",
               bvalid, bresp, awready);
    end
    bready = 1;
    @(negedge aclk);
    total++;
    if (bvalid !== 1'b1 || bresp !== SLVERR || awready !== 1'b1) begin
      bad++;
      $display("FAIL bp second beat: got bvalid=%b bresp=%0d awready=%b want 1/1/1",
               bvalid, bresp, awready);
    end
    @(negedge aclk);
    total++;
    if (bvalid !== 1'b0 || reg_q[32 +: 32] !== 32'h0) begin
      bad++;
      $display("FAIL bp drain: got bvalid=%b reg1=%h want 0/0", bvalid, reg_q[32 +: 32]);
    end
  endtask

  task automatic test_wide_bank();
    logic [63:0] d;
    logic [63:0] exp64 [4];
    logic [1:0]  r;
    bit          to;
    wr64(32'h1008, 64'h1111_2222_3333_4444, 8'hF0, r, to);
    total++;
    if (to || r !== OKAY || s_reg_q[64 +: 64] !== 64'h1111_2222_0000_0000) begin
      bad++;
      $display("FAIL wide strobe: got %0d reg1=%h want 0/1111222200000000", r, s_reg_q[64 +: 64]);
    end
    wr64(32'h1018, 64'h0123_4567_89AB_CDEF, 8'hFF, r, to);
    rd64(32'h1004, d, r, to);
    total++;
    if (to || d !== 64'h0 || r !== SLVERR) begin
      bad++;
      $display("FAIL wide misaligned: got %h/%0d want 0/1", d, r);
    end
    rd64(32'h0008, d, r, to);
    total++;
    if (to || d !== 64'h0 || r !== SLVERR) begin
      bad++;
      $display("FAIL wide below base: got %h/%0d want 0/1", d, r);
    end
    exp64[0] = 64'h0; exp64[1] = 64'h1111_2222_0000_0000;
    exp64[2] = 64'h0; exp64[3] = 64'h0123_4567_89AB_CDEF;
    @(negedge aclk);
    s_araddr = 32'h1000; s_arvalid = 1; s_rready = 1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s_arready !== 1'b1) begin
        bad++;
        $display("FAIL b2b arready %0d: got %b want 1", i, s_arready);
      end
      @(negedge aclk);
      if (i < 3) s_araddr = 32'h1000 + 32'((i + 1) * 8);
      else s_arvalid = 0;
      total++;
      if (s_rvalid !== 1'b1 || s_rdata !== exp64[i] || s_rresp !== OKAY) begin
        bad++;
        $display("FAIL b2b read %0d: got v=%b %h/%0d want 1 %h/0",
                 i, s_rvalid, s_rdata, s_rresp, exp64[i]);
      end
    end
    @(negedge aclk);
    total++;
    if (s_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b done: got rvalid=%b want 0", s_rvalid);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge aclk);
    wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1; awvalid = 0; bready = 1;
    s_wdata = 64'h5555; s_wstrb = 8'hFF; s_wvalid = 1; s_awvalid = 0; s_bready = 1;
    @(negedge aclk);
    wvalid = 0; s_wvalid = 0;
    total++;
    if ({wready, s_wready} !== 2'b00) begin
      bad++;
      $display("FAIL mid held: got w=%b s_w=%b want 0/0", wready, s_wready);
    end
    aresetn = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    total++;
    if ({wready, s_wready, awready, bvalid} !== 4'b1110 || reg_q !== '0 || s_reg_q !== '0) begin
      bad++;
      $display("FAIL mid reset: got w/sw/aw/b=%b want 1110", {wready, s_wready, awready, bvalid});
    end
    awaddr = 32'h08; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    repeat (3) @(negedge aclk);
    total++;
    if (bvalid !== 1'b0 || wready !== 1'b1 || reg_q !== '0) begin
      bad++;
      $display("FAIL mid dropped w: got bvalid=%b wready=%b reg2=%h want 0/1/0",
               bvalid, wready, reg_q[64 +: 32]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_strobe_order();
    test_read_only();
    test_bad_addr();
    test_b_backpressure();
    test_wide_bank();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
